cfg_axi_initiator: RTL
======================

CFG_AXI_INITIATOR -- requirements
Module: cfg_axi_initiator

Interface
REQ-001 Parameter AXI_DATA_WIDTH, default 64, AXI data width in bits; legal values are 32 and 64.
REQ-002 Parameter AXI_ID, default 4'd0, constant ID driven on AWID and ARID.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  clock.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 req_valid_i/req_ready_o  in/out  1/1  command handshake.
REQ-007 req_write_i  in  1  1=write, 0=read.
REQ-008 req_addr_i  in  32  start byte address.
REQ-009 req_len_i  in  8  beat count minus 1 (0..255).
REQ-010 wr_valid_i/wr_ready_o, wr_data_i, wr_strb_i  in/out, in, in  1/1, AXI_DATA_WIDTH, AXI_DATA_WIDTH/8  write-data stream.
REQ-011 rd_valid_o/rd_ready_i, rd_data_o, rd_last_o  out/in, out, out  1/1, AXI_DATA_WIDTH, 1  read-data stream.
REQ-012 done_o  out  1  one-cycle completion pulse.
REQ-013 done_resp_o  out  2 (axi_resp_t)  completion status.
REQ-014 AXI AW channel (axi_awvalid_o, axi_awready_i, axi_awaddr_o[31:0], axi_awid_o[3:0], axi_awlen_o[7:0], axi_awsize_o[2:0], axi_awburst_o[1:0]): master AW channel.
REQ-015 AXI W channel (axi_wvalid_o, axi_wready_i, axi_wdata_o, axi_wstrb_o, axi_wlast_o): master W channel.
REQ-016 AXI B channel (axi_bvalid_i, axi_bready_o, axi_bresp_i, axi_bid_i[3:0]): master B channel.
REQ-017 AXI AR channel (axi_arvalid_o, axi_arready_i, axi_araddr_o, axi_arid_o, axi_arlen_o, axi_arsize_o, axi_arburst_o): master AR channel.
REQ-018 AXI R channel (axi_rvalid_i, axi_rready_o, axi_rdata_i, axi_rresp_i, axi_rid_i, axi_rlast_i): master R channel.

Function
REQ-019 The FSM SHALL have states IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, and DONE; req_ready_o = (state==IDLE).
REQ-020 On a request handshake, the block SHALL register addr, len, and write, then move to WADDR or RADDR, asserting AWVALID or ARVALID on the next cycle.
REQ-021 Address check: if addr is not aligned to AXI_DATA_WIDTH/8, or if addr[11:0] + (len+1)*bytes exceeds 4096, the block SHALL go directly to DONE with SLVERR and issue no AXI traffic.
REQ-022 AW/AR: len = registered len; size = log2(AXI_DATA_WIDTH/8); burst = INCR (2'b01); ID = AXI_ID; VALID SHALL be held with stable payload until READY.
REQ-023 WADDR SHALL advance to WDATA on AW handshake; W is issued strictly after AW.
REQ-024 WDATA: axi_wvalid_o = wr_valid_i, wr_ready_o = axi_wready_i, and data/strb SHALL pass combinationally.
REQ-025 The beat counter SHALL increment on each W handshake.
REQ-026 axi_wlast_o SHALL equal (beat counter == len).
REQ-027 WDATA SHALL go to WRESP on the last-beat handshake.
REQ-028 WRESP: axi_bready_o = 1; on B handshake, the block SHALL capture bresp and go to DONE.
REQ-029 RADDR SHALL go to RDATA on AR handshake.
REQ-030 RDATA: rd_valid_o = axi_rvalid_i, axi_rready_o = rd_ready_i, and rd_data_o/rd_last_o = rdata/rlast combinationally.
REQ-031 RDATA SHALL count beats and go to DONE on the handshake with rlast=1.
REQ-032 Read status SHALL be the worst (numerically largest) rresp over all beats.
REQ-033 Read status SHALL be forced to SLVERR if rlast arrives at a beat count other than len.
REQ-034 Mismatched rid or bid SHALL force SLVERR.
REQ-035 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-036 done_resp_o SHALL hold its value until the next request is accepted.
REQ-037 len=0 SHALL give a single beat with wlast asserted on the first beat.
REQ-038 len=255 SHALL give 256 beats; the counter is 8 bits and SHALL NOT wrap before wlast.
REQ-039 wr_ready_o, rd_valid_o, and all AXI VALID/READY outputs SHALL be 0 outside their owning state.

Reset
REQ-040 On rst_i, the state SHALL be IDLE, and the counter and all registered fields SHALL be 0.
REQ-041 On rst_i, all VALID/READY outputs, done_o, and done_resp_o (OKAY) SHALL be 0.
REQ-042 Reset mid-burst SHALL abort immediately; no completion or recovery is guaranteed toward the AXI slave.

Structure
REQ-043 axi_resp_t, AXI_OKAY, AXI_SLVERR, and BURST_INCR SHALL come from amba_axi_pkg.
REQ-044 The FSM state enum SHALL be local to the module.
REQ-045 The module SHALL be a single module with no sub-module.

Verification
REQ-046 Write: addr=0x100, len=3, data 1..4, slave with random AW/W/B stalls -> one AW (awlen=3), four W beats with wlast only on the 4th, done_o with OKAY.
REQ-047 Read: addr=0x200, len=0, rresp=OKAY, rd_ready_i low for 3 cycles -> RREADY stays low during the stall; a single beat is delivered with rd_last_o=1; done_resp_o=OKAY.
REQ-048 Read: len=2 with the 2nd beat rresp=SLVERR -> done_resp_o=SLVERR.
REQ-049 Read: len=2 with rlast on beat 1 -> done_resp_o=SLVERR.
REQ-050 Request addr=0xFF8, len=1 (64-bit), and request addr=0x104 -> no AWVALID/ARVALID; done_o on the 2nd cycle after acceptance; SLVERR.
REQ-051 Assert rst_i during the 2nd W beat of len=3 -> all outputs return to reset values the same cycle; a new request afterwards completes with OKAY.

Source files
------------

// File: rtl/amba_axi_pkg.sv
// Shared AXI encodings used by the configuration-space bus masters.
package amba_axi_pkg;

  typedef logic [1:0] axi_resp_t;
  typedef logic [1:0] axi_burst_t;

  localparam axi_resp_t  AXI_OKAY    = 2'b00;
  localparam axi_resp_t  AXI_EXOKAY  = 2'b01;
  localparam axi_resp_t  AXI_SLVERR  = 2'b10;
  localparam axi_resp_t  AXI_DECERR  = 2'b11;

  localparam axi_burst_t BURST_FIXED = 2'b00;
  localparam axi_burst_t BURST_INCR  = 2'b01;
  localparam axi_burst_t BURST_WRAP  = 2'b10;

  // Responses are ordered by severity, so the worst one is the larger code.
  function automatic axi_resp_t resp_worst(input axi_resp_t a, input axi_resp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cfg_axi_initiator.sv
// Single-burst AXI master: turns one command into one INCR burst (write or read)
// and reports a one-cycle completion pulse with the aggregated response.
module cfg_axi_initiator
  import amba_axi_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter logic [3:0]  AXI_ID         = 4'd0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,

  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_write_i,
  input  logic [31:0]                 req_addr_i,
  input  logic [7:0]                  req_len_i,

  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   wr_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] wr_strb_i,

  output logic                        rd_valid_o,
  input  logic                        rd_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   rd_data_o,
  output logic                        rd_last_o,

  output logic                        done_o,
  output axi_resp_t                   done_resp_o,

  output logic                        axi_awvalid_o,
  input  logic                        axi_awready_i,
  output logic [31:0]                 axi_awaddr_o,
  output logic [3:0]                  axi_awid_o,
  output logic [7:0]                  axi_awlen_o,
  output logic [2:0]                  axi_awsize_o,
  output logic [1:0]                  axi_awburst_o,

  output logic                        axi_wvalid_o,
  input  logic                        axi_wready_i,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata_o,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb_o,
  output logic                        axi_wlast_o,

  input  logic                        axi_bvalid_i,
  output logic                        axi_bready_o,
  input  logic [1:0]                  axi_bresp_i,
  input  logic [3:0]                  axi_bid_i,

  output logic                        axi_arvalid_o,
  input  logic                        axi_arready_i,
  output logic [31:0]                 axi_araddr_o,
  output logic [3:0]                  axi_arid_o,
  output logic [7:0]                  axi_arlen_o,
  output logic [2:0]                  axi_arsize_o,
  output logic [1:0]                  axi_arburst_o,

  input  logic                        axi_rvalid_i,
  output logic                        axi_rready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata_i,
  input  logic [1:0]                  axi_rresp_i,
  input  logic [3:0]                  axi_rid_i,
  input  logic                        axi_rlast_i
);

  localparam int unsigned BYTES    = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFFS_W   = $clog2(BYTES);
  localparam logic [2:0]  AXI_SIZE = 3'(OFFS_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WDATA = 3'd2,
    S_WRESP = 3'd3,
    S_RADDR = 3'd4,
    S_RDATA = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic        write_q;
  logic [7:0]  beat_q;
  axi_resp_t   resp_q;
  logic        err_q;

  logic [13:0] span_end;
  logic        addr_bad;
  logic        last_beat;
  logic        w_hs;
  logic        r_hs;

  // A burst must be beat-aligned and stay inside its 4 KiB page.
  assign span_end  = {2'b00, req_addr_i[11:0]} + (({6'd0, req_len_i} + 14'd1) * 14'(BYTES));
  assign addr_bad  = (req_addr_i[OFFS_W-1:0] != '0) || (span_end > 14'd4096);

  assign last_beat = (beat_q == len_q);
  assign w_hs      = axi_wvalid_o & axi_wready_i;
  assign r_hs      = axi_rvalid_i & axi_rready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      write_q <= 1'b0;
      beat_q  <= '0;
      resp_q  <= AXI_OKAY;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            len_q   <= req_len_i;
            write_q <= req_write_i;
            beat_q  <= '0;
            resp_q  <= AXI_OKAY;
            err_q   <= addr_bad;
            if (addr_bad)         state_q <= S_DONE;
            else if (req_write_i) state_q <= S_WADDR;
            else                  state_q <= S_RADDR;
          end
        end
        S_WADDR: if (axi_awready_i) state_q <= S_WDATA;
        S_WDATA: begin
          if (w_hs) begin
            beat_q <= beat_q + 8'd1;
            if (last_beat) state_q <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (axi_bvalid_i) begin
            resp_q <= axi_bresp_i;
            if (axi_bid_i != AXI_ID) err_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_RADDR: if (axi_arready_i) state_q <= S_RDATA;
        S_RDATA: begin
          if (r_hs) begin
            beat_q <= beat_q + 8'd1;
            resp_q <= resp_worst(resp_q, axi_rresp_i);
            // An early/late RLAST or a foreign ID is a protocol error, reported as SLVERR.
            if ((axi_rid_i != AXI_ID) || (axi_rlast_i && !last_beat)) err_q <= 1'b1;
            if (axi_rlast_i) state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign done_resp_o   = err_q ? AXI_SLVERR : resp_q;

  assign axi_awvalid_o = (state_q == S_WADDR) & write_q;
  assign axi_awaddr_o  = addr_q;
  assign axi_awid_o    = AXI_ID;
  assign axi_awlen_o   = len_q;
  assign axi_awsize_o  = AXI_SIZE;
  assign axi_awburst_o = BURST_INCR;

  assign axi_wvalid_o  = (state_q == S_WDATA) & wr_valid_i;
  assign wr_ready_o    = (state_q == S_WDATA) & axi_wready_i;
  assign axi_wdata_o   = wr_data_i;
  assign axi_wstrb_o   = wr_strb_i;
  assign axi_wlast_o   = last_beat;

  assign axi_bready_o  = (state_q == S_WRESP);

  assign axi_arvalid_o = (state_q == S_RADDR) & ~write_q;
  assign axi_araddr_o  = addr_q;
  assign axi_arid_o    = AXI_ID;
  assign axi_arlen_o   = len_q;
  assign axi_arsize_o  = AXI_SIZE;
  assign axi_arburst_o = BURST_INCR;

  assign rd_valid_o    = (state_q == S_RDATA) & axi_rvalid_i;
  assign axi_rready_o  = (state_q == S_RDATA) & rd_ready_i;
  assign rd_data_o     = axi_rdata_i;
  assign rd_last_o     = axi_rlast_i;

endmodule
